bat_position_ctrl: RTL and testbench

//  Upstream of the bat display stage. Converts player up/down buttons into a per-frame bat

---
 rtl/bat_position_ctrl_pkg.sv | 34 +++
 rtl/bat_position_ctrl_if.sv | 27 ++
 rtl/bat_position_ctrl_sync_edge.sv | 29 ++
 rtl/bat_position_ctrl.sv | 140 ++++++++++++++
 tb/tb_bat_position_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/bat_position_ctrl_pkg.sv
// Shared pong screen constants and the bat direction-state encoding.
// Imported by every bat and ball block.
package bat_position_ctrl_pkg;

  localparam int TOP_WALL_END   = 15;
  localparam int BOT_WALL_START = 240;
  localparam int BAT_H          = 32;

  localparam int V_MIN_DEF   = TOP_WALL_END + 1;
  localparam int V_MAX_DEF   = BOT_WALL_START - BAT_H;
  localparam int Y_RESET_DEF = (V_MIN_DEF + V_MAX_DEF) / 2;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  // Both or neither pressed means stand still.
  function automatic dir_e next_dir(
    input logic up,
    input logic dn
  );
    dir_e d;
    d = DIR_IDLE;
    unique case (1'b1)
      (up && !dn): d = DIR_UP;
      (dn && !up): d = DIR_DOWN;
      default:     d = DIR_IDLE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bat_position_ctrl_if.sv
// Video timing in, bat position and start line out.
// master drives timing and buttons, slave is the bat controller.
interface bat_position_ctrl_if #(
  parameter int VPOS_W = 9
);

  logic              hsync;
  logic              vsync;
  logic [VPOS_W-1:0] vpos;
  logic              btn_up;
  logic              btn_down;
  logic              start;
  logic [VPOS_W-1:0] bat_y;

  modport master (
    output hsync, vsync, vpos,
    output btn_up, btn_down,
    input  start, bat_y
  );

  modport slave (
    input  hsync, vsync, vpos,
    input  btn_up, btn_down,
    output start, bat_y
  );

endinterface

// File: rtl/bat_position_ctrl_sync_edge.sv
// Two-flop synchroniser with a one-clock rising-edge pulse.
module bat_position_ctrl_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_level,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_prev;

endmodule

// File: rtl/bat_position_ctrl.sv
// Per-player bat position: buttons move the bat once per frame on vsync.
// Define BAT_ACCEL_EN to double the step after a long hold.
module bat_position_ctrl
  import bat_position_ctrl_pkg::*;
#(
  parameter int VPOS_W       = 9,
  parameter int V_MIN        = V_MIN_DEF,
  parameter int V_MAX        = V_MAX_DEF,
  parameter int Y_RESET      = Y_RESET_DEF,
  parameter int STEP         = 2,
  parameter int ACCEL_FRAMES = 8
) (
  input logic clk,
  input logic reset,
  bat_position_ctrl_if.slave bus
);

  localparam int SW = VPOS_W + 1;

  localparam logic signed [SW-1:0] L_MIN_S = SW'(V_MIN);
  localparam logic signed [SW-1:0] L_MAX_S = SW'(V_MAX);

  localparam logic [VPOS_W-1:0] L_MIN_U = VPOS_W'(V_MIN);
  localparam logic [VPOS_W-1:0] L_MAX_U = VPOS_W'(V_MAX);
  localparam logic [VPOS_W-1:0] L_RST_U = VPOS_W'(Y_RESET);

  logic w_up;
  logic w_dn;
  logic w_tick;
  logic w_vs_lvl_unused;
  logic w_up_rise_unused;
  logic w_dn_rise_unused;
  logic w_hsync_unused;

  dir_e r_dir;
  dir_e w_dir;

  logic [VPOS_W-1:0] r_bat_y;
  logic [VPOS_W-1:0] w_next_y;

  logic signed [SW-1:0] w_cur_s;
  logic signed [SW-1:0] w_step_s;
  logic signed [SW-1:0] w_sum_s;

  logic r_start;
  logic r_hsync;

`ifdef BAT_ACCEL_EN
  logic [3:0] r_hold;
  logic [3:0] w_hold;
`else
  localparam int ACCEL_UNUSED = ACCEL_FRAMES;
  dir_e w_dir_unused;
  assign w_dir_unused = r_dir;
`endif

  bat_position_ctrl_sync_edge u_vs (
    .clk     (clk),
    .reset   (reset),
    .i_d     (bus.vsync),
    .o_level (w_vs_lvl_unused),
    .o_rise  (w_tick)
  );

  bat_position_ctrl_sync_edge u_up (
    .clk     (clk),
    .reset   (reset),
    .i_d     (bus.btn_up),
    .o_level (w_up),
    .o_rise  (w_up_rise_unused)
  );

  bat_position_ctrl_sync_edge u_dn (
    .clk     (clk),
    .reset   (reset),
    .i_d     (bus.btn_down),
    .o_level (w_dn),
    .o_rise  (w_dn_rise_unused)
  );

  // One extra sign bit so a step past either wall clamps instead of wrapping.
  always_comb begin
    w_dir    = next_dir(w_up, w_dn);
    w_cur_s  = $signed({1'b0, r_bat_y});
    w_step_s = SW'(STEP);
`ifdef BAT_ACCEL_EN
    w_hold = '0;
    if (w_dir == r_dir && w_dir != DIR_IDLE)
      w_hold = (r_hold == '1) ? r_hold : r_hold + 4'd1;
    if (w_hold >= 4'(ACCEL_FRAMES))
      w_step_s = SW'(2 * STEP);
`endif
    w_sum_s  = w_cur_s;
    w_next_y = r_bat_y;
    unique case (w_dir)
      DIR_UP: begin
        w_sum_s  = w_cur_s - w_step_s;
        w_next_y = (w_sum_s < L_MIN_S) ?
                   L_MIN_U : w_sum_s[VPOS_W-1:0];
      end
      DIR_DOWN: begin
        w_sum_s  = w_cur_s + w_step_s;
        w_next_y = (w_sum_s > L_MAX_S) ?
                   L_MAX_U : w_sum_s[VPOS_W-1:0];
      end
      default: begin
        w_next_y = r_bat_y;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dir   <= DIR_IDLE;
      r_bat_y <= L_RST_U;
      r_start <= 1'b0;
      r_hsync <= 1'b0;
`ifdef BAT_ACCEL_EN
      r_hold  <= '0;
`endif
    end else begin
      r_hsync <= bus.hsync;
      r_start <= (bus.vpos == r_bat_y);
      if (w_tick) begin
        r_dir   <= w_dir;
        r_bat_y <= w_next_y;
`ifdef BAT_ACCEL_EN
        r_hold  <= w_hold;
`endif
      end
    end
  end

  // Registered hsync is kept only as a line-boundary reference.
  assign w_hsync_unused = r_hsync;

  assign bus.start = r_start;
  assign bus.bat_y = r_bat_y;

endmodule

// File: tb/tb_bat_position_ctrl.sv
// Scoreboard bench for bat_position_ctrl: frames push expected start lines,
// a negedge monitor pops and compares on every rising start.
module tb_bat_position_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int mon_e;

  logic       prev_start = 1'b0;
  logic [8:0] prev_vpos  = 9'd255;

`ifdef BAT_ACCEL_EN
  int exp6[10] = '{114, 116, 118, 120, 122,
                   124, 126, 128, 132, 136};
`else
  int exp6[10] = '{114, 116, 118, 120, 122,
                   124, 126, 128, 130, 132};
`endif

  bat_position_ctrl_if #(.VPOS_W(9)) a ();
  bat_position_ctrl_if #(.VPOS_W(9)) b ();

  bat_position_ctrl dut_a (
    .clk   (clk),
    .reset (rst),
    .bus   (a)
  );

  bat_position_ctrl #(.Y_RESET(19)) dut_b (
    .clk   (clk),
    .reset (rst),
    .bus   (b)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", n, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (a.start && !prev_start) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL start_extra: rose at vpos %0d, required none",
                 a.vpos);
      end else begin
        mon_e = exp_q.pop_front();
        check("start_line", int'(a.vpos), mon_e);
        check("start_bat_y", int'(a.bat_y), mon_e);
        check("start_latency", int'(prev_vpos), mon_e);
      end
    end
    prev_start = a.start;
    prev_vpos  = a.vpos;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    check("rst_bat_y_a", int'(a.bat_y), 112);
    check("rst_start_a", int'(a.start), 0);
    check("rst_bat_y_b", int'(b.bat_y), 19);
    rst = 1'b0;
    step(1);
  endtask

  task automatic scan_a();
    for (int l = 0; l < 256; l++) begin
      a.vpos  = 9'(l);
      a.hsync = 1'b1;
      step(1);
      a.hsync = 1'b0;
      step(1);
    end
    a.vpos = 9'd255;
    step(2);
  endtask

  task automatic frame_a(input logic up, input logic dn,
                         input int req, input bit scan);
    a.btn_up   = up;
    a.btn_down = dn;
    step(3);
    a.vsync = 1'b1;
    step(4);
    a.vsync = 1'b0;
    step(2);
    check("frame_bat_y", int'(a.bat_y), req);
    if (scan) begin
      exp_q.push_back(req);
      scan_a();
    end
  endtask

  task automatic frame_b(input logic up, input logic dn,
                         input int req);
    b.btn_up   = up;
    b.btn_down = dn;
    step(3);
    b.vsync = 1'b1;
    step(4);
    b.vsync = 1'b0;
    step(2);
    check("b_bat_y", int'(b.bat_y), req);
  endtask

  initial begin
    int ey;
    int n;
    a.hsync = 1'b0; a.vsync = 1'b0; a.vpos = 9'd255;
    a.btn_up = 1'b0; a.btn_down = 1'b0;
    b.hsync = 1'b0; b.vsync = 1'b0; b.vpos = 9'd255;
    b.btn_up = 1'b0; b.btn_down = 1'b0;

    do_reset();
    frame_a(1'b0, 1'b0, 112, 1'b1);
    frame_a(1'b0, 1'b0, 112, 1'b1);

    for (int i = 0; i < 5; i++)
      frame_a(1'b1, 1'b1, 112, 1'b0);
    frame_a(1'b0, 1'b1, 114, 1'b1);
    frame_a(1'b0, 1'b1, 116, 1'b1);
    frame_a(1'b0, 1'b0, 116, 1'b0);

    do_reset();
    frame_a(1'b1, 1'b0, 110, 1'b1);
    frame_a(1'b1, 1'b0, 108, 1'b1);
    frame_a(1'b1, 1'b0, 106, 1'b1);
    frame_a(1'b0, 1'b0, 106, 1'b0);

    do_reset();
    ey = 112;
    while (ey < 150) begin
      ey += 2;
      frame_a(1'b0, 1'b1, ey, 1'b0);
      if ((ey - 112) % 8 == 0)
        frame_a(1'b0, 1'b0, ey, 1'b0);
    end
    frame_a(1'b0, 1'b0, 150, 1'b0);
    exp_q.push_back(150);
    for (int l = 0; l < 256; l++) begin
      a.vpos  = 9'(l);
      a.hsync = 1'b1;
      step(1);
      a.hsync = 1'b0;
      if (l == 150) begin
        @(negedge clk);
        #1;
        check("pre_reset_start", int'(a.start), 1);
        rst = 1'b1;
        #1;
        check("mid_reset_start", int'(a.start), 0);
        check("mid_reset_bat_y", int'(a.bat_y), 112);
        @(posedge clk);
        #1;
        rst = 1'b0;
      end else begin
        step(1);
      end
    end
    a.vpos = 9'd255;
    step(2);
    frame_a(1'b0, 1'b0, 112, 1'b1);

    do_reset();
    for (int i = 0; i < 10; i++)
      frame_a(1'b0, 1'b1, exp6[i], 1'b0);
    frame_a(1'b0, 1'b0, exp6[9], 1'b1);

    do_reset();
    ey = 19;
    n  = 0;
    while (ey < 207) begin
      ey += 2;
      frame_b(1'b0, 1'b1, ey);
      n++;
      if (n % 4 == 0)
        frame_b(1'b0, 1'b0, ey);
    end
    frame_b(1'b0, 1'b0, 207);
    frame_b(1'b0, 1'b1, 208);
    frame_b(1'b0, 1'b1, 208);
    frame_b(1'b0, 1'b0, 208);

    do_reset();
    frame_b(1'b1, 1'b0, 17);
    frame_b(1'b1, 1'b0, 16);
    frame_b(1'b1, 1'b0, 16);
    frame_b(1'b0, 1'b0, 16);

    step(4);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
